// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Purpose  : MIPS CP0 privileged registers, precise exception/ERET commit and
//            registered pipeline redirect. Timer (Count/Compare/TI) is built
//            only when CP0_TIMER_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module cp0_unit #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           data_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_pending_o,
  output logic                  timer_int_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o
);

  localparam logic [4:0] c_reg_badvaddr = 5'd8;
  localparam logic [4:0] c_reg_count    = 5'd9;
  localparam logic [4:0] c_reg_compare  = 5'd11;
  localparam logic [4:0] c_reg_status   = 5'd12;
  localparam logic [4:0] c_reg_cause    = 5'd13;
  localparam logic [4:0] c_reg_epc      = 5'd14;
  localparam logic [4:0] c_reg_prid     = 5'd15;
  localparam logic [4:0] c_reg_config   = 5'd16;

  logic [7:0]            r_im;
  logic                  r_exl;
  logic                  r_ie;
  logic                  r_bd;
  logic [1:0]            r_ip_sw;
  logic [4:0]            r_exc_code;
  logic [31:0]           r_epc;
  logic [31:0]           r_badvaddr;
  logic [NUM_HW_INT-1:0] r_int_hw;
  logic                  r_flush;
  logic [31:0]           r_flush_pc;

  logic                  w_wr;
  logic [31:0]           w_count;
  logic [31:0]           w_compare;
  logic                  w_ti;
  logic [5:0]            w_ip_raw;
  logic [5:0]            w_ip_hw;
  logic [31:0]           w_status;
  logic [31:0]           w_cause;

  // MTC0 only lands when no exception or ERET commits in the same cycle
  assign w_wr = we_i & ~exc_valid_i & ~eret_i;

`ifdef CP0_TIMER_EN
  localparam int c_pre_w = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [c_pre_w-1:0] r_pre;
  logic [31:0]        r_count;
  logic [31:0]        r_compare;
  logic               r_ti;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr && waddr_i == c_reg_count) begin
        r_count <= data_i;
        r_pre   <= '0;
      end else if (r_pre == c_pre_w'(COUNT_DIV - 1)) begin
        r_pre   <= '0;
        r_count <= r_count + 32'd1;
      end else begin
        r_pre <= r_pre + c_pre_w'(1);
      end
      // Compare write wins over a match seen on the old values
      if (w_wr && waddr_i == c_reg_compare) begin
        r_compare <= data_i;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare && r_compare != 32'd0) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_count   = r_count;
  assign w_compare = r_compare;
  assign w_ti      = r_ti;
`else
  logic w_unused_timer_cfg;
  assign w_unused_timer_cfg = (COUNT_DIV > 0);
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_ti      = 1'b0;
`endif

  for (genvar gi = 0; gi < 6; gi++) begin : g_ip_hw
    if (gi < NUM_HW_INT) begin : g_line
      assign w_ip_raw[gi] = r_int_hw[gi];
    end else begin : g_tied
      assign w_ip_raw[gi] = 1'b0;
    end
  end

  assign w_ip_hw  = w_ip_raw | {w_ti, 5'b0_0000};
  assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'd0, w_ip_hw, r_ip_sw, 1'b0, r_exc_code, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_sw    <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_int_hw   <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
    end else begin
      r_int_hw <= int_i;
      r_flush  <= exc_valid_i | eret_i;
      if (exc_valid_i) begin
        // Nested exception keeps the original return point
        if (!r_exl) begin
          r_epc <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          r_bd  <= exc_bd_i;
        end
        r_exc_code <= exc_code_i;
        r_exl      <= 1'b1;
        r_flush_pc <= EXC_VECTOR;
        if (exc_code_i == 5'd4 || exc_code_i == 5'd5) begin
          r_badvaddr <= exc_badvaddr_i;
        end
      end else if (eret_i) begin
        r_exl      <= 1'b0;
        r_flush_pc <= r_epc;
      end else if (we_i) begin
        case (waddr_i)
          c_reg_status: begin
            r_im  <= data_i[15:8];
            r_exl <= data_i[1];
            r_ie  <= data_i[0];
          end
          c_reg_cause: r_ip_sw <= data_i[9:8];
          c_reg_epc:   r_epc   <= data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (raddr_i)
      c_reg_badvaddr: data_o = r_badvaddr;
      c_reg_count:    data_o = w_count;
      c_reg_compare:  data_o = w_compare;
      c_reg_status:   data_o = w_status;
      c_reg_cause:    data_o = w_cause;
      c_reg_epc:      data_o = r_epc;
      c_reg_prid:     data_o = PRID_VAL;
      c_reg_config:   data_o = CONFIG_VAL;
      default:        data_o = '0;
    endcase
  end

  assign status_o      = w_status;
  assign cause_o       = w_cause;
  assign epc_o         = r_epc;
  assign int_pending_o = r_ie & ~r_exl & (|(r_im & w_cause[15:8]));
  assign timer_int_o   = w_ti;
  assign flush_o       = r_flush;
  assign flush_pc_o    = r_flush_pc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_unit
// Purpose  : Directed plus randomized bench for cp0_unit against a behavioural
//            register model (follows CP0_TIMER_EN the same way as the DUT).
// Revision : 1.0  initial release
// ============================================================================
module tb_cp0_unit;

  localparam int          NUM_HW_INT = 6;
  localparam int          COUNT_DIV  = 2;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] PRID_VAL   = 32'h004C_0102;
  localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;
`ifdef CP0_TIMER_EN
  localparam bit c_timer_en = 1'b1;
`else
  localparam bit c_timer_en = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [4:0]            raddr_i;
  logic [31:0]           data_i;
  logic [NUM_HW_INT-1:0] int_i;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic [31:0]           exc_pc_i;
  logic                  exc_bd_i;
  logic [31:0]           exc_badvaddr_i;
  logic                  eret_i;
  logic [31:0]           data_o, status_o, cause_o, epc_o, flush_pc_o;
  logic                  int_pending_o, timer_int_o, flush_o;

  always #5 clk = ~clk;

  cp0_unit #(
    .NUM_HW_INT(NUM_HW_INT), .COUNT_DIV(COUNT_DIV), .EXC_VECTOR(EXC_VECTOR),
    .PRID_VAL(PRID_VAL), .CONFIG_VAL(CONFIG_VAL)
  ) u_dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .exc_valid_i(exc_valid_i),
    .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
    .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i), .data_o(data_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .int_pending_o(int_pending_o), .timer_int_o(timer_int_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit hold_raddr = 1'b1;

  // Architectural view of CP0 kept by the bench
  logic [31:0] m_count, m_compare, m_epc, m_bad, m_fpc;
  int          m_pre;
  logic        m_ti, m_exl, m_ie, m_bd, m_flush;
  logic [7:0]  m_im;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [5:0]  m_inth;

  logic [4:0] c_rd_map [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd10};
  logic [4:0] c_wr_map [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0040_0000;
    s[15:8] = m_im;
    s[1] = m_exl;
    s[0] = m_ie;
    return s;
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = '0;
    for (int k = 0; k < NUM_HW_INT; k++) c[10 + k] = m_inth[k];
    c[15] = c[15] | m_ti;
    c[31] = m_bd;
    c[30] = m_ti;
    c[9:8] = m_ipsw;
    c[6:2] = m_code;
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return c_timer_en ? m_count : 32'd0;
      5'd11: return c_timer_en ? m_compare : 32'd0;
      5'd12: return m_status();
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return PRID_VAL;
      5'd16: return CONFIG_VAL;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = '0; m_compare = '0; m_epc = '0; m_bad = '0; m_fpc = '0;
    m_pre = 0; m_ti = 1'b0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
    m_flush = 1'b0; m_im = '0; m_ipsw = '0; m_code = '0; m_inth = '0;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_update();
    logic [31:0] old_count, old_cmp;
    bit wr;
    old_count = m_count;
    old_cmp   = m_compare;
    wr = we_i && !exc_valid_i && !eret_i;
    if (rst) begin
      model_reset();
      return;
    end
    if (c_timer_en) begin
      m_pre = m_pre + 1;
      if (m_pre == COUNT_DIV) begin
        m_pre = 0;
        m_count = m_count + 32'd1;
      end
      if (wr && waddr_i == 5'd9) begin
        m_count = data_i;
        m_pre = 0;
      end
      if (wr && waddr_i == 5'd11) begin
        m_compare = data_i;
        m_ti = 1'b0;
      end else if (old_count == old_cmp && old_cmp != 0) begin
        m_ti = 1'b1;
      end
    end
    m_inth = 6'(int_i);
    m_flush = exc_valid_i || eret_i;
    if (exc_valid_i) begin
      if (!m_exl) begin
        m_epc = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        m_bd = exc_bd_i;
      end
      m_code = exc_code_i;
      m_exl = 1'b1;
      m_fpc = EXC_VECTOR;
      if (exc_code_i == 5'd4 || exc_code_i == 5'd5) m_bad = exc_badvaddr_i;
    end else if (eret_i) begin
      m_fpc = m_epc;
      m_exl = 1'b0;
    end else if (wr) begin
      if (waddr_i == 5'd12) begin
        m_im = data_i[15:8];
        m_exl = data_i[1];
        m_ie = data_i[0];
      end
      if (waddr_i == 5'd13) m_ipsw = data_i[9:8];
      if (waddr_i == 5'd14) m_epc = data_i;
    end
  endtask

  task automatic cycle();
    logic [31:0] cause_m;
    if (!hold_raddr) raddr_i = c_rd_map[$urandom_range(0, 8)];
    #1;
    cause_m = m_cause();
    check("data_o", data_o, m_read(raddr_i));
    check("status", status_o, m_status());
    check("cause", cause_o, cause_m);
    check("epc", epc_o, m_epc);
    check("pending", {31'd0, int_pending_o},
          {31'd0, m_ie & ~m_exl & (|(m_im & cause_m[15:8]))});
    check("timer_int", {31'd0, timer_int_o}, {31'd0, m_ti});
    check("flush", {31'd0, flush_o}, {31'd0, m_flush});
    check("flush_pc", flush_pc_o, m_fpc);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    cycle();
    we_i = 1'b0;
  endtask

  logic [31:0] c_rst_val [8];

  initial begin
    c_rst_val = '{32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0, PRID_VAL, CONFIG_VAL};
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0; int_i = '0;
    exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0; exc_bd_i = 1'b0;
    exc_badvaddr_i = '0; eret_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    idle();

    // Reset values of every mapped register
    for (int i = 0; i < 8; i++) begin
      raddr_i = c_rd_map[i];
      #1;
      check("rst_read", data_o, c_rst_val[i]);
      check("rst_flush", {31'd0, flush_o}, 32'd0);
      cycle();
    end

    // Timer: Count=0, Compare=5, TI after ten increments' worth of clocks
    raddr_i = 5'd9;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    for (int i = 0; i < 9; i++) cycle();
    check("ti_early", {31'd0, timer_int_o}, 32'd0);
    cycle();
    check("ti_set", {31'd0, timer_int_o}, {31'd0, c_timer_en});
    for (int i = 0; i < 3; i++) cycle();
    check("ti_sticky", {31'd0, timer_int_o}, {31'd0, c_timer_en});
    mtc0(5'd11, 32'd9);
    check("ti_clear", {31'd0, timer_int_o}, 32'd0);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFE);
    for (int i = 0; i < 6; i++) cycle();

    // Interrupt path: IE + IM[10] with int_i[0]
    raddr_i = 5'd13;
    mtc0(5'd12, 32'h0000_0401);
    int_i = 6'd1;
    cycle();
    int_i = 6'd0;
    check("irq_pend", {31'd0, int_pending_o}, 32'd1);
    cycle();
    check("irq_drop", {31'd0, int_pending_o}, 32'd0);
    int_i = 6'd1;
    cycle();
    mtc0(5'd12, 32'h0000_0403);
    check("irq_exl", {31'd0, int_pending_o}, 32'd0);
    int_i = 6'd0;
    mtc0(5'd12, 32'h0000_0000);

    // Exception in delay slot with address error
    raddr_i = 5'd8;
    exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h8000_1004;
    exc_bd_i = 1'b1; exc_badvaddr_i = 32'h0000_0123;
    cycle();
    check("exc_epc", epc_o, 32'h8000_1000);
    check("exc_bd", {31'd0, cause_o[31]}, 32'd1);
    check("exc_code", {27'd0, cause_o[6:2]}, 32'd4);
    check("exc_badv", data_o, 32'h0000_0123);
    check("exc_exl", {31'd0, status_o[1]}, 32'd1);
    check("exc_flush", {31'd0, flush_o}, 32'd1);
    check("exc_target", flush_pc_o, 32'hBFC0_0380);

    // Nested exception, back-to-back
    exc_code_i = 5'd8; exc_pc_i = 32'h8000_2000; exc_bd_i = 1'b0;
    cycle();
    exc_valid_i = 1'b0;
    check("nest_epc", epc_o, 32'h8000_1000);
    check("nest_code", {27'd0, cause_o[6:2]}, 32'd8);
    check("nest_flush", {31'd0, flush_o}, 32'd1);

    eret_i = 1'b1;
    cycle();
    eret_i = 1'b0;
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);
    check("eret_flush", {31'd0, flush_o}, 32'd1);
    check("eret_target", flush_pc_o, 32'h8000_1000);
    cycle();
    check("flush_once", {31'd0, flush_o}, 32'd0);

    // Exception beats ERET and MTC0 in the same cycle, then reset
    exc_valid_i = 1'b1; exc_code_i = 5'd12; exc_pc_i = 32'h8000_3000; exc_bd_i = 1'b0;
    eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hDEAD_BEEF;
    cycle();
    idle();
    check("prio_epc", epc_o, 32'h8000_3000);
    check("prio_target", flush_pc_o, EXC_VECTOR);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_flush2", {31'd0, flush_o}, 32'd0);
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);

    // Randomized traffic
    hold_raddr = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      exc_valid_i = ($urandom_range(0, 19) == 0);
      eret_i = ($urandom_range(0, 19) == 0);
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = c_wr_map[$urandom_range(0, 7)];
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
        data_i = m_count + 32'($urandom_range(0, 8));
      else
        data_i = $urandom;
      exc_code_i = 5'($urandom_range(0, 31));
      exc_pc_i = $urandom;
      exc_bd_i = 1'($urandom_range(0, 1));
      exc_badvaddr_i = $urandom;
      if ($urandom_range(0, 5) == 0) int_i = int_i ^ 6'(1 << $urandom_range(0, 5));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
